// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-side arbiter.
// Optional grant statistics are enabled with FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_MAX_BURST  = 4;
    localparam int CNT_WIDTH      = 16;

    // Index width that stays at least one bit wide for a single entry.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating priority encoder: first set bit of req starting at ptr.
// Purely combinational so it can also serve a read-side scheduler.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N   = DEF_NUM_REQ,
    parameter int IDW = id_width(DEF_NUM_REQ)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] idx,
    output logic           found
);

    // Scan from the farthest offset down so the nearest one wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                idx   = IDW'((int'(ptr) + k) % N);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter for the FIFO write port.
// Define FIFO_ARB_STATS_EN to build the per-requester grant counters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            fifo_full,
    input  logic                            fifo_almostfull,
    output logic                            wr_en,
    output logic [DATA_WIDTH-1:0]           data_in,
    output logic [id_width(NUM_REQ)-1:0]    grant_id,
    output logic                            busy,
    output logic [NUM_REQ*CNT_WIDTH-1:0]    grant_count
);

    localparam int IDW = id_width(NUM_REQ);
    localparam int BCW = id_width(MAX_BURST);

    arb_state_e            state;
    arb_state_e            next_state;
    logic [IDW-1:0]        rr_ptr;
    logic [IDW-1:0]        pick_idx;
    logic [IDW-1:0]        next_ptr;
    logic                  pick_found;
    logic [BCW-1:0]        burst_cnt;
    logic                  stall;
    logic                  owner_valid;
    logic [DATA_WIDTH-1:0] owner_data;
    logic                  xfer;
    logic                  last_word;
    logic                  burst_end;

    rr_pick #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // A registered write in flight takes the last free slot.
    assign stall = fifo_full | (fifo_almostfull & wr_en);

    // Select the current owner's valid and data.
    always_comb begin
        owner_valid = 1'b0;
        owner_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IDW'(i)) begin
                owner_valid = req_valid[i];
                owner_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign xfer      = (state == BURST) && owner_valid && !stall;
    assign last_word = burst_cnt == BCW'(MAX_BURST - 1);
    assign burst_end = (state == BURST) && ((xfer && last_word) || !owner_valid);
    assign next_ptr  = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state: arbitrate in IDLE, leave BURST on limit or owner drop.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (pick_found) next_state = BURST;
            BURST:   if (burst_end)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Ready only to the owner, only in BURST, only without stall.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (state == BURST) && (grant_id == IDW'(i)) && !stall;
        end
    end

    // Registered write port, grant bookkeeping and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en     <= 1'b0;
            data_in   <= '0;
            grant_id  <= '0;
            busy      <= 1'b0;
            burst_cnt <= '0;
            rr_ptr    <= '0;
        end else begin
            wr_en <= xfer;
            if (xfer) begin
                data_in   <= owner_data;
                burst_cnt <= burst_cnt + BCW'(1);
            end
            if (state == IDLE && pick_found) begin
                grant_id  <= pick_idx;
                burst_cnt <= '0;
                busy      <= 1'b1;
            end
            if (burst_end) begin
                busy   <= 1'b0;
                rr_ptr <= next_ptr;
            end
        end
    end

`ifdef FIFO_ARB_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        logic [CNT_WIDTH-1:0] cnt;

        // Saturating count of words accepted from requester g.
        always_ff @(posedge clk) begin
            if (rst)
                cnt <= '0;
            else if (req_valid[g] && req_ready[g] && cnt != '1)
                cnt <= cnt + CNT_WIDTH'(1);
        end

        assign grant_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt;
    end

    // At most one requester may ever see ready.
    always_comb begin
        if (!rst) begin
            assert ($onehot0(req_ready))
            else $error("req_ready not one-hot: %b", req_ready);
        end
    end
`else
    assign grant_count = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter.
// Honours FIFO_ARB_STATS_EN for the grant counter expectations.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              fifo_full;
    logic              fifo_almostfull;
    logic              wr_en;
    logic [DW-1:0]     data_in;
    logic [1:0]        grant_id;
    logic              busy;
    logic [N*16-1:0]   grant_count;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .fifo_full       (fifo_full),
        .fifo_almostfull (fifo_almostfull),
        .wr_en           (wr_en),
        .data_in         (data_in),
        .grant_id        (grant_id),
        .busy            (busy),
        .grant_count     (grant_count)
    );

    always #5 clk = ~clk;

    // Reference model: owner = -1 means no grant held.
    int          m_owner;
    int          m_gid;
    int          m_ptr;
    int          m_cnt;
    bit          m_wr;
    int unsigned m_gc [N];
    logic [DW-1:0] exp_q [$];
    int          seq [N];

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] word_of(int i);
        return {4'(i), 12'(seq[i])};
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_gid   = 0;
        m_ptr   = 0;
        m_cnt   = 0;
        m_wr    = 0;
        for (int i = 0; i < N; i++) m_gc[i] = 0;
    endtask

    task automatic check_counts(string tag);
        for (int i = 0; i < N; i++) begin
`ifdef FIFO_ARB_STATS_EN
            check($sformatf("%s_gc%0d", tag, i),
                  64'(grant_count[i*16 +: 16]), 64'(m_gc[i]));
`else
            check($sformatf("%s_gc%0d", tag, i),
                  64'(grant_count[i*16 +: 16]), 64'd0);
`endif
        end
    endtask

    // One clock cycle: check registered state, drive, check ready, step model.
    task automatic cycle(int phase);
        logic [N-1:0] v;
        logic         f;
        logic         af;
        logic         r;
        logic [N-1:0] exp_rdy;
        bit           stall;
        bit           xfer;

        check("busy", 64'(busy), 64'(m_owner >= 0));
        check("grant_id", 64'(grant_id), 64'(m_gid));
        check("wr_en", 64'(wr_en), 64'(m_wr));

        v  = '0;
        f  = 1'b0;
        af = 1'b0;
        r  = 1'b0;
        case (phase)
            0: for (int i = 0; i < N; i++) v[i] = $urandom_range(0, 99) < 70;
            1: begin
                v  = '1;
                f  = $urandom_range(0, 9) < 2;
                af = $urandom_range(0, 9) < 3;
            end
            2: v = 4'b0100;
            3: begin
                for (int i = 0; i < N; i++) v[i] = $urandom_range(0, 99) < 50;
                f  = $urandom_range(0, 9) < 1;
                af = $urandom_range(0, 9) < 2;
                r  = $urandom_range(0, 99) < 2;
            end
            default: v = '0;
        endcase
        rst             = r;
        req_valid       = v;
        fifo_full       = f;
        fifo_almostfull = af;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = word_of(i);
        #1;

        stall   = f || (af && m_wr);
        exp_rdy = (m_owner >= 0 && !stall) ? N'(1 << m_owner) : '0;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));

        for (int i = 0; i < N; i++)
            if (v[i] && req_ready[i] && !r) seq[i]++;

        if (r) begin
            model_reset();
        end else if (m_owner < 0) begin
            m_wr = 0;
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && v[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_gid   = m_owner;
                    m_cnt   = 0;
                end
            end
        end else begin
            xfer = v[m_owner] && !stall;
            m_wr = xfer;
            if (xfer) begin
                exp_q.push_back({4'(m_owner), 12'(seq[m_owner] - 1)});
                m_cnt++;
                if (m_gc[m_owner] < 32'hFFFF) m_gc[m_owner]++;
            end
            if ((xfer && m_cnt == MB) || !v[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every FIFO write must match the oldest expected word.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(data_in), 64'hDEAD_0000);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                check("write_data", 64'(data_in), 64'(e));
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) seq[i] = 1;
        rst             = 1'b1;
        req_valid       = '0;
        req_data        = '0;
        fifo_full       = 1'b0;
        fifo_almostfull = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant_id", 64'(grant_id), 64'd0);
        check("rst_data_in", 64'(data_in), 64'd0);
        check("rst_grant_count", 64'(grant_count), 64'd0);

        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 400; c++) cycle(p);
            check_counts($sformatf("ph%0d", p));
        end
        for (int c = 0; c < 12; c++) cycle(4);
        check_counts("end");
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the synchronous FIFO among NUM_REQ producers.
- Each producer uses a valid/ready handshake.
- Grants are burst-locked up to MAX_BURST words, and the block respects FIFO full/almostfull back-pressure.
- Sits between producer agents and the FIFO DUT write side (wr_en, data_in) in the FIFO subsystem.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_WIDTH, 16: FIFO data width.
- MAX_BURST, 4: max consecutive words per grant (1..16).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester data valid.
- req_data  in  NUM_REQ*DATA_WIDTH  flattened data; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester accept (combinational).
- fifo_full  in  1  FIFO full flag.
- fifo_almostfull  in  1  FIFO has exactly one free slot.
- wr_en  out  1  registered FIFO write enable.
- data_in  out  DATA_WIDTH  registered FIFO write data.
- grant_id  out  $clog2(NUM_REQ)  current owner index.
- busy  out  1  high while in BURST.
- grant_count  out  NUM_REQ*16  per-requester accepted-word counters (see Optional Feature).

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, rr_ptr=0, burst_cnt=0, wr_en=0, data_in=0, grant_id=0, busy=0, grant_count=0. Any in-flight write is dropped. Reset has priority over all other events.
- stall = fifo_full | (fifo_almostfull & wr_en). A registered write in flight consumes the last slot.
- Transfer on requester i occurs when req_valid[i] & req_ready[i].
- req_ready[i] = (state==BURST) & (grant_id==i) & ~stall. It is never high in IDLE.
- IDLE:
  - If any req_valid is set, pick the first valid index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Next cycle: grant_id=winner, burst_cnt=0, busy=1, state=BURST.
  - No transfer occurs in an IDLE cycle (one-cycle arbitration bubble).
- BURST:
  - On a transfer: wr_en<=1, data_in<=owner's req_data, burst_cnt++. Otherwise wr_en<=0.
  - Write latency: accepted word appears on wr_en/data_in exactly 1 cycle after the handshake.
  - Burst ends (state<=IDLE, busy<=0, rr_ptr<=grant_id+1 mod NUM_REQ) when either:
    - a transfer occurs with burst_cnt==MAX_BURST-1, or
    - req_valid[grant_id]==0, regardless of stall.
  - A stall alone never ends a burst. The owner keeps the grant and burst_cnt holds.
- Data from a non-owner is never written.
- Requester valid changes in IDLE are sampled only at arbitration.
- MAX_BURST=1: every grant ends after one word.
- grant_id holds its last value in IDLE.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- Defined:
  - grant_count[i] increments by 1 on each transfer of requester i.
  - Counters are 16-bit, saturate at 16'hFFFF, and clear on rst.
  - An immediate assertion fires if req_ready is ever one-hot violated.
- Undefined: grant_count is driven constant 0 and no counters are synthesized. The port is kept so the interface is stable.

Decomposition:
- Package fifo_arb_pkg holds:
  - arb_state_e enum {IDLE, BURST};
  - localparam function for id width ($clog2 guard for NUM_REQ=1);
  - default width constants.
- Sub-module rr_pick: combinational rotate/priority-encode (req vector, rr_ptr) -> winner index plus found flag. Reusable for a later read-side scheduler.

Test Plan:
1. Reset mid-burst:
   - Stimulus: req0 streaming, assert rst for 1 cycle after 2 words.
   - Response: wr_en=0, busy=0, grant_id=0 next cycle; third word not written.
2. Single requester:
   - Stimulus: req2 valid with data 0x0001..0x0006, MAX_BURST=4.
   - Response: 4 writes, 1 IDLE bubble, re-grant to 2, 2 writes; FIFO order 0x0001..0x0006.
3. Round-robin fairness:
   - Stimulus: all 4 valid continuously, MAX_BURST=1.
   - Response: grant_id sequence 0,1,2,3,0,...; each requester gets 1 word per 4 grants.
4. Back-pressure:
   - Stimulus: fifo_almostfull=1 while wr_en=1.
   - Response: req_ready=0 next cycle.
   - Stimulus: fifo_full=1 for 3 cycles.
   - Response: no wr_en, burst_cnt frozen, owner unchanged; resumes on release.
5. Early release:
   - Stimulus: owner 1 drops valid after 2 of 4 words.
   - Response: burst ends, rr_ptr=2, requester 3 valid is granted next.
6. Stats (FIFO_ARB_STATS_EN):
   - Stimulus: 10 words from req0, 3 from req3.
   - Response: grant_count[0]=10, grant_count[3]=3, others 0.
   - Without the macro: all grant_count bits are 0.
